// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone command master.
// Bus widths, FSM state encoding and response error codes.

package wb_master_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    localparam logic RSP_ERR_NONE    = 1'b0;
    localparam logic RSP_ERR_TIMEOUT = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Strobe-without-ACK watchdog counter for wb_cmd_master.
// Compiled only when WB_CMD_MASTER_TIMEOUT_EN is defined, since it is only instantiated then.

`ifdef WB_CMD_MASTER_TIMEOUT_EN
module wb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_last;

    assign at_last   = (cnt_q == CntLast);
    assign expired_o = en_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_last) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle master driven by a valid/ready command stream.
// Optional strobe timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN.

module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,

    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i
);

    wb_state_e           state_q, state_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic                rsp_err_q, rsp_err_d;

    logic bus_active;
    logic bus_idle;
    logic tmo_expired;

    assign bus_active = (state_q == StBus);
    assign bus_idle   = !bus_active;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    wb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clr_i    (bus_idle),
        .en_i     (bus_active),
        .expired_o(tmo_expired)
    );
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES ^ bus_idle;
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                // ready_q is low for the first cycle after reset, holding off commands.
                if (cmd_valid && ready_q) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    state_d = StBus;
                end
            end
            StBus: begin
                // ACK takes priority over an expiry sampled on the same edge.
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    rsp_err_d = RSP_ERR_NONE;
                    state_d   = StResp;
                end else if (tmo_expired) begin
                    rsp_dat_d = '0;
                    rsp_err_d = RSP_ERR_TIMEOUT;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= RSP_ERR_NONE;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

    assign wbm_cyc_o = bus_active;
    assign wbm_stb_o = bus_active;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master with a behavioural Wishbone responder.
// Timeout scenarios run only when WB_CMD_MASTER_TIMEOUT_EN is defined.

module tb_wb_cmd_master;

    localparam int unsigned TMO = 8;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int TMO_LIMIT = TMO;
`else
    localparam int TMO_LIMIT = 32'h4000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we_o, ack;
    logic [31:0] adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    wb_cmd_master #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o (we_o),
        .wbm_adr_o(adr_o),
        .wbm_dat_o(dat_o),
        .wbm_sel_o(sel_o),
        .wbm_ack_i(ack),
        .wbm_dat_i(dat_i)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One command through the full handshake; waits = ACK in STB cycle waits+1.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input int waits, input logic [31:0] rdat,
                           input int hold);
        int          n;
        int          stb_n;
        bit          exp_err;
        logic [31:0] exp_dat;
        logic [32:0] exp_rsp;
        logic [32:0] got;

        exp_err = (waits >= TMO_LIMIT);
        exp_dat = (exp_err || we) ? 32'h0 : rdat;

        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = wdat;
        cmd_sel   = sel;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_ready", 128'(cmd_ready), 128'(1));
        exp_q.push_back({exp_err, exp_dat});
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr   = ~adr;
        cmd_dat   = ~wdat;
        cmd_sel   = ~sel;
        cmd_we    = ~we;

        stb_n = 0;
        n = 0;
        while (n < 200) begin
            if (!stb) break;
            check_eq("bus_fields", 128'({cyc, we_o, adr_o, dat_o, sel_o}),
                     128'({1'b1, we, adr, wdat, sel}));
            stb_n++;
            ack   = (stb_n == waits + 1);
            dat_i = ack ? rdat : 32'hBAD0_0000 ^ 32'(stb_n);
            @(negedge clk);
            n++;
        end
        ack = 1'b0;
        check_eq("stb_cycles", 128'(stb_n), 128'(exp_err ? TMO : waits + 1));
        check_eq("rsp_valid_rise", 128'({rsp_valid, cyc}), 128'({1'b1, 1'b0}));

        // Stray ACKs during backpressure must not disturb the held response.
        for (int i = 0; i < hold; i++) begin
            ack   = 1'b1;
            dat_i = 32'h5555_0000 + 32'(i);
            check_eq("rsp_hold", 128'({rsp_valid, rsp_err, rsp_dat, cmd_ready, cyc, stb}),
                     128'({1'b1, exp_err, exp_dat, 3'b000}));
            @(negedge clk);
        end
        ack       = 1'b0;
        rsp_ready = 1'b1;
        if (exp_q.size() != 0) begin
            exp_rsp = exp_q.pop_front();
            got     = {rsp_err, rsp_dat};
            check_eq("rsp_data", 128'(got), 128'(exp_rsp));
        end else begin
            check_eq("scoreboard_empty", 128'(1), 128'(0));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_hs", 128'({rsp_valid, cmd_ready, stb}), 128'({1'b0, 1'b1, 1'b0}));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        ack       = 1'b0;
        dat_i     = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 128'({cmd_ready, rsp_valid, rsp_err, rsp_dat, cyc, stb, we_o, adr_o, dat_o, sel_o}),
                 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", 128'(cmd_ready), 128'(1));

        run_txn(1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF, 1, 32'hFFFF_FFFF, 0);
        run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 3, 32'h1234_5678, 0);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1000, 32'h1111_2222, 0);
        run_txn(1'b1, 32'h3000_0010, 32'hAAAA_5555, 4'h3, 1000, 32'h0, 2);
        run_txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, 0, 32'h600D_F00D, 0);
`endif
        run_txn(1'b0, 32'h3000_0018, 32'h0, 4'hF, TMO - 1, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, 32'h3000_001C, 32'h0, 4'hC, 0, 32'hCAFE_F00D, 5);
        for (int k = 0; k < 6; k++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 2)));
        end

        // Reset during BUS: transaction abandoned, no response.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0020;
        cmd_dat   = 32'h0BAD_CAFE;
        cmd_sel   = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("rst_txn_stb", 128'({cyc, stb}), 128'(2'b11));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_bus",
                 128'({cmd_ready, rsp_valid, rsp_err, rsp_dat, cyc, stb, we_o, adr_o, dat_o, sel_o}),
                 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_no_rsp", 128'({rsp_valid, stb, cmd_ready}), 128'(3'b001));
        run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 32'h8765_4321, 0);

        check_eq("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
